// File: rtl/pcs_10g_pkg.sv
// Shared types and constants for the 10G PCS TX path: scheduler states, the
// start-block preamble pattern and the inter-packet-gap arithmetic.
package pcs_10g_pkg;

  localparam int KEEP_W_DEF        = 4;
  localparam int GB_PERIOD_DEF     = 32;
  localparam int IPG_MIN_BYTES_DEF = 12;

  // Byte0 = 0xFB start control, bytes1-6 preamble, byte7 SFD.
  localparam logic [63:0] PREAMBLE_SFD = 64'hD555_5555_5555_55FB;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_TERM  = 3'd2,
    ST_IPG   = 3'd3,
    ST_DRAIN = 3'd4
  } tx_state_e;

  // A terminate with k data bytes already carries 7-k idle bytes, so the idle
  // blocks still owed are ceil((min_bytes - 7 + k) / 8) = (min_bytes + k) / 8.
  function automatic logic [2:0] ipg_blocks(input int unsigned k, input int unsigned min_bytes);
    return 3'((min_bytes + k) / 32'd8);
  endfunction

endpackage

// File: rtl/pcs_10g_gb_pause.sv
// Free-running gearbox slot counter; flags the one cycle per period in which
// the 64b/66b gearbox cannot take a block.
module pcs_10g_gb_pause #(
  parameter int GB_PERIOD = 32
) (
  input  logic clk,
  input  logic reset,
  output logic pause_o
);

  localparam int CNT_W = $clog2(GB_PERIOD + 1);

  logic [CNT_W-1:0] gb_cnt_q;
  logic [CNT_W-1:0] gb_cnt_d;

  // Next count: 0..GB_PERIOD then wrap.
  always_comb begin
    if (gb_cnt_q == CNT_W'(GB_PERIOD)) begin
      gb_cnt_d = '0;
    end else begin
      gb_cnt_d = gb_cnt_q + CNT_W'(1'b1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      gb_cnt_q <= '0;
    end else begin
      gb_cnt_q <= gb_cnt_d;
    end
  end

  assign pause_o = (gb_cnt_q == CNT_W'(GB_PERIOD));

endmodule

// File: rtl/pcs_10g_tx_sched.sv
// MAC-to-encoder TX scheduler: inserts start/terminate blocks and the minimum
// IPG, honours the gearbox pause slot and aborts frames on MAC underrun.
module pcs_10g_tx_sched #(
  parameter int DATA_W        = 64,
  parameter int KEEP_W        = pcs_10g_pkg::KEEP_W_DEF,
  parameter int GB_PERIOD     = pcs_10g_pkg::GB_PERIOD_DEF,
  parameter int IPG_MIN_BYTES = pcs_10g_pkg::IPG_MIN_BYTES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mac_valid_i,
  output logic              mac_ready_o,
  input  logic [DATA_W-1:0] mac_data_i,
  input  logic [KEEP_W-1:0] mac_keep_i,
  input  logic              mac_last_i,
  input  logic              mac_err_i,
  output logic              enc_v_o,
  output logic              enc_idle_v_o,
  output logic              enc_start_o,
  output logic              enc_last_o,
  output logic              enc_err_o,
  output logic [DATA_W-1:0] enc_data_o,
  output logic [KEEP_W-1:0] enc_keep_o
);

  import pcs_10g_pkg::*;

  tx_state_e         state_q, state_d;
  logic [2:0]        ipg_cnt_q, ipg_cnt_d;
  logic              enc_v_q, enc_v_d;
  logic              enc_idle_q, enc_idle_d;
  logic              enc_start_q, enc_start_d;
  logic              enc_last_q, enc_last_d;
  logic              enc_err_q, enc_err_d;
  logic [DATA_W-1:0] enc_data_q, enc_data_d;
  logic [KEEP_W-1:0] enc_keep_q, enc_keep_d;
  logic              pause_s;

  pcs_10g_gb_pause #(.GB_PERIOD(GB_PERIOD)) u_gb_pause (
    .clk     (clk),
    .reset   (reset),
    .pause_o (pause_s)
  );

  assign mac_ready_o = !pause_s && ((state_q == ST_DATA) || (state_q == ST_DRAIN));

  // Next-state and next-block selection; a pause slot freezes everything.
  always_comb begin
    state_d     = state_q;
    ipg_cnt_d   = ipg_cnt_q;
    enc_v_d     = 1'b1;
    enc_idle_d  = 1'b0;
    enc_start_d = 1'b0;
    enc_last_d  = 1'b0;
    enc_err_d   = 1'b0;
    enc_data_d  = '0;
    enc_keep_d  = '0;
    if (pause_s) begin
      enc_v_d     = 1'b0;
      enc_idle_d  = enc_idle_q;
      enc_start_d = enc_start_q;
      enc_last_d  = enc_last_q;
      enc_err_d   = enc_err_q;
      enc_data_d  = enc_data_q;
      enc_keep_d  = enc_keep_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mac_valid_i) begin
            enc_start_d = 1'b1;
            enc_data_d  = DATA_W'(PREAMBLE_SFD);
            state_d     = ST_DATA;
          end else begin
            enc_idle_d = 1'b1;
          end
        end
        ST_DATA: begin
          if (!mac_valid_i) begin
            enc_err_d = 1'b1;
            state_d   = ST_DRAIN;
          end else if (!mac_last_i) begin
            enc_err_d  = mac_err_i;
            enc_data_d = mac_err_i ? '0 : mac_data_i;
          end else if (mac_err_i) begin
            enc_err_d = 1'b1;
            state_d   = ST_TERM;
          end else if (mac_keep_i >= KEEP_W'(4'd8)) begin
            enc_data_d = mac_data_i;
            state_d    = ST_TERM;
          end else begin
            enc_last_d = 1'b1;
            enc_keep_d = mac_keep_i;
            enc_data_d = mac_data_i;
            ipg_cnt_d  = ipg_blocks(32'(mac_keep_i), IPG_MIN_BYTES);
            state_d    = ST_IPG;
          end
        end
        ST_TERM: begin
          enc_last_d = 1'b1;
          ipg_cnt_d  = ipg_blocks(32'd0, IPG_MIN_BYTES);
          state_d    = ST_IPG;
        end
        ST_IPG: begin
          enc_idle_d = 1'b1;
          ipg_cnt_d  = ipg_cnt_q - 3'd1;
          if (ipg_cnt_q <= 3'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IPG;
          end
        end
        ST_DRAIN: begin
          enc_idle_d = 1'b1;
          if (mac_valid_i && mac_last_i) begin
            ipg_cnt_d = ipg_blocks(32'd0, IPG_MIN_BYTES);
            state_d   = ST_IPG;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          enc_idle_d = 1'b1;
          state_d    = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ipg_cnt_q   <= 3'd0;
      enc_v_q     <= 1'b0;
      enc_idle_q  <= 1'b1;
      enc_start_q <= 1'b0;
      enc_last_q  <= 1'b0;
      enc_err_q   <= 1'b0;
      enc_data_q  <= '0;
      enc_keep_q  <= '0;
    end else begin
      state_q     <= state_d;
      ipg_cnt_q   <= ipg_cnt_d;
      enc_v_q     <= enc_v_d;
      enc_idle_q  <= enc_idle_d;
      enc_start_q <= enc_start_d;
      enc_last_q  <= enc_last_d;
      enc_err_q   <= enc_err_d;
      enc_data_q  <= enc_data_d;
      enc_keep_q  <= enc_keep_d;
    end
  end

  assign enc_v_o      = enc_v_q;
  assign enc_idle_v_o = enc_idle_q;
  assign enc_start_o  = enc_start_q;
  assign enc_last_o   = enc_last_q;
  assign enc_err_o    = enc_err_q;
  assign enc_data_o   = enc_data_q;
  assign enc_keep_o   = enc_keep_q;

endmodule

// File: tb/tb_pcs_10g_tx_sched.sv
// Bench for pcs_10g_tx_sched: random frames from a MAC source model, expected
// encoder block stream built per frame, plus gearbox pause timing checks.
module tb_pcs_10g_tx_sched;

  localparam logic [63:0] PRE = 64'hD555_5555_5555_55FB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mac_valid_i = 1'b0;
  logic        mac_ready_o;
  logic [63:0] mac_data_i = 64'd0;
  logic [3:0]  mac_keep_i = 4'd0;
  logic        mac_last_i = 1'b0;
  logic        mac_err_i = 1'b0;
  logic        enc_v_o, enc_idle_v_o, enc_start_o, enc_last_o, enc_err_o;
  logic [63:0] enc_data_o;
  logic [3:0]  enc_keep_o;

  always #5 clk = ~clk;

  pcs_10g_tx_sched dut (
    .clk          (clk),
    .reset        (reset),
    .mac_valid_i  (mac_valid_i),
    .mac_ready_o  (mac_ready_o),
    .mac_data_i   (mac_data_i),
    .mac_keep_i   (mac_keep_i),
    .mac_last_i   (mac_last_i),
    .mac_err_i    (mac_err_i),
    .enc_v_o      (enc_v_o),
    .enc_idle_v_o (enc_idle_v_o),
    .enc_start_o  (enc_start_o),
    .enc_last_o   (enc_last_o),
    .enc_err_o    (enc_err_o),
    .enc_data_o   (enc_data_o),
    .enc_keep_o   (enc_keep_o)
  );

  typedef struct packed {
    logic        idle;
    logic        start;
    logic        last;
    logic        err;
    logic [3:0]  keep;
    logic [63:0] data;
  } blk_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
    logic        drop;
  } beat_t;

  beat_t src_q[$];
  blk_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    pcnt = 0;
  bit    seen_start = 1'b0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic blk_t mk(input logic i, input logic s, input logic l, input logic e,
                              input logic [3:0] k, input logic [63:0] d);
    blk_t b;
    b.idle = i; b.start = s; b.last = l; b.err = e; b.keep = k; b.data = d;
    return b;
  endfunction

  // One frame: n beats, last beat holds kl bytes, err on beat err_idx,
  // valid dropped for one cycle in front of beat drop_idx (-1 = none).
  task automatic add_frame(input int n, input int kl, input int err_idx, input int drop_idx);
    bit aborted = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, PRE));
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.last = (i == n - 1);
      b.keep = b.last ? 4'(kl) : 4'd8;
      b.err  = (i == err_idx);
      b.drop = (i == drop_idx);
      src_q.push_back(b);
      if (aborted) begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0));
      end else if (b.drop) begin
        aborted = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 64'd0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0));
      end else if (!b.last) begin
        exp_q.push_back(b.err ? mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 64'd0)
                              : mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, b.data));
      end else if (b.err || kl == 8) begin
        exp_q.push_back(b.err ? mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 64'd0)
                              : mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, b.data));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0));
      end else begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'(kl), b.data));
        for (int g = 0; g < (5 + kl + 7) / 8; g++)
          exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0));
      end
    end
    if (aborted) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0));
  endtask

  always @(posedge clk) begin
    if (reset) pcnt <= 0;
    else pcnt <= pcnt + 1;
  end

  // Pause timing and block stream, sampled away from the active edge.
  always @(negedge clk) begin
    blk_t got;
    if (pcnt > 0) begin
      chk("enc_v", 72'(enc_v_o), 72'(((pcnt - 1) % 33) != 32));
      if ((pcnt % 33) == 32) chk("ready_pause", 72'(mac_ready_o), 72'(1'b0));
      if (enc_v_o) begin
        got = mk(enc_idle_v_o, enc_start_o, enc_last_o, enc_err_o, enc_keep_o, enc_data_o);
        if (!seen_start && (got == mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0))) begin
          seen_start = 1'b0;
        end else if (exp_q.size() > 0) begin
          seen_start = 1'b1;
          chk("block", got, exp_q.pop_front());
        end else if (seen_start) begin
          chk("trail_idle", got, mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0));
        end
      end
    end
  end

  initial begin
    int  cyc;
    bit  dropped;
    bit  go;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_flags", 72'({enc_v_o, enc_idle_v_o, enc_start_o, enc_last_o, enc_err_o, mac_ready_o}),
          72'(6'b010000));
      chk("rst_data", 72'({enc_keep_o, enc_data_o}), 72'(68'd0));
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", 72'({enc_v_o, enc_idle_v_o, enc_start_o, enc_last_o, enc_err_o}),
          72'(5'b11000));
    end

    add_frame(2, 8, -1, -1);
    add_frame(2, 5, -1, -1);
    add_frame(3, 8, 1, -1);
    add_frame(4, 8, -1, 1);
    add_frame(2, 6, 1, -1);
    add_frame(1, 0, -1, -1);
    for (int f = 0; f < 30; f++) begin
      int n;
      n = int'($urandom_range(1, 5));
      add_frame(n, int'($urandom_range(0, 8)),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1);
    end

    cyc = 0;
    dropped = 1'b0;
    while (src_q.size() > 0 && cyc < 20000) begin
      if (src_q[0].drop && !dropped && mac_ready_o) begin
        mac_valid_i = 1'b0;
        dropped = 1'b1;
      end else begin
        mac_valid_i = 1'b1;
        mac_data_i  = src_q[0].data;
        mac_keep_i  = src_q[0].keep;
        mac_last_i  = src_q[0].last;
        mac_err_i   = src_q[0].err;
      end
      go = mac_valid_i && mac_ready_o;
      @(negedge clk);
      cyc++;
      if (go) begin
        void'(src_q.pop_front());
        dropped = 1'b0;
      end
    end
    mac_valid_i = 1'b0;
    mac_last_i  = 1'b0;
    mac_err_i   = 1'b0;
    for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("src_drained", 72'(src_q.size()), 72'(0));
    chk("exp_drained", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
